regs: RTL and testbench

- General-purpose register file for the picoMIPS datapath: 8 registers x 8 bits, two combinational read ports, one synchronous write port.
- Register 0 is hard-wired to zero.
- The write target is the register addressed by Raddr2, which is the instruction's destination field. Write data comes from the ALU or immediate result path.
- Read data feeds the ALU operand inputs.

---
 rtl/regs.sv | 71 +++++++
 tb/tb_regs.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/regs.sv
// ---------------------------------------------------------------------------
// regs -- general-purpose register file for the picoMIPS datapath.
//
// 2**a registers of n bits each. There are two combinational read ports and
// one synchronous write port. Register 0 has no storage and always reads zero.
// Writes go to the register addressed by Raddr2, which is the instruction's
// destination field, so Raddr2 is both a read address and the write address.
//
// Ports
//   clk      in   1   system clock; writes take effect on the rising edge
//   n_reset  in   1   asynchronous active-low reset; clears every register
//   w        in   1   write enable, active high
//   Wdata    in   n   signed write data (ALU / immediate result)
//   Raddr1   in   a   read address, port 1
//   Raddr2   in   a   read address, port 2 and write address
//   Rdata1   out  n   signed contents of register Raddr1 (0 for address 0)
//   Rdata2   out  n   signed contents of register Raddr2 (0 for address 0)
// ---------------------------------------------------------------------------
module regs #(
  parameter int n = 8,
  parameter int a = 3
) (
  input  logic                clk,
  input  logic                n_reset,
  input  logic                w,
  input  logic signed [n-1:0] Wdata,
  input  logic        [a-1:0] Raddr1,
  input  logic        [a-1:0] Raddr2,
  output logic signed [n-1:0] Rdata1,
  output logic signed [n-1:0] Rdata2
);

  localparam int NREG = 2 ** a;

  // Read-side view of every register. Entry 0 is a constant zero, so the read
  // muxes need no special case for address 0.
  logic [n-1:0]    w_gpr [NREG];

  // One-hot write strobe per register, computed from the shared address.
  logic [NREG-1:0] w_wr_sel;

  assign w_gpr[0]    = '0;
  assign w_wr_sel[0] = 1'b0;  // writes to r0 are discarded

  genvar gi;
  generate
    for (gi = 1; gi < NREG; gi++) begin : g_reg
      logic [n-1:0] r_q;

      assign w_wr_sel[gi] = w && (Raddr2 == a'(gi));

      // Asynchronous clear. The reset branch takes priority over a write on
      // the same edge. The first edge after release can write normally.
      always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
          r_q <= '0;
        end else if (w_wr_sel[gi]) begin
          r_q <= Wdata;
        end
      end

      assign w_gpr[gi] = r_q;
    end
  endgenerate

  // The read path is purely combinational and has no write bypass. A value
  // written on an edge becomes visible only after that edge.
  assign Rdata1 = w_gpr[Raddr1];
  assign Rdata2 = w_gpr[Raddr2];

endmodule

// File: tb/tb_regs.sv
// ---------------------------------------------------------------------------
// tb_regs -- directed self-checking testbench for the regs register file.
// ---------------------------------------------------------------------------
module tb_regs;

  logic              clk;
  logic              n_reset;
  logic              w;
  logic signed [7:0] Wdata;
  logic        [2:0] Raddr1;
  logic        [2:0] Raddr2;
  logic signed [7:0] Rdata1;
  logic signed [7:0] Rdata2;

  int tests_run;
  int tests_failed;

  regs #(.n(8), .a(3)) dut (
    .clk     (clk),
    .n_reset (n_reset),
    .w       (w),
    .Wdata   (Wdata),
    .Raddr1  (Raddr1),
    .Raddr2  (Raddr2),
    .Rdata1  (Rdata1),
    .Rdata2  (Rdata2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hold reset, check reads during reset, release between edges, then sweep.
  task automatic test_reset();
    n_reset = 1'b0; w = 1'b0; Wdata = 8'h00; Raddr1 = 3'd3; Raddr2 = 3'd6;
    #12;
    tests_run++;
    if (Rdata1 !== 8'h00 || Rdata2 !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_held: Rdata1=%h Rdata2=%h expected 00 00", Rdata1, Rdata2);
    end
    @(negedge clk);
    n_reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      Raddr1 = 3'(i); Raddr2 = 3'(7 - i);
      #1;
      tests_run++;
      if (Rdata1 !== 8'h00 || Rdata2 !== 8'h00) begin
        tests_failed++;
        $display("FAIL reset_sweep[%0d]: Rdata1=%h Rdata2=%h expected 00 00", i, Rdata1, Rdata2);
      end
    end
    $display("[TB] test_reset done");
  endtask

  task automatic test_write_r0();
    @(negedge clk);
    Raddr1 = 3'd0; Raddr2 = 3'd0; Wdata = 8'hFF; w = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if (Rdata1 !== 8'h00 || Rdata2 !== 8'h00) begin
      tests_failed++;
      $display("FAIL write_r0: Rdata1=%h Rdata2=%h expected 00 00", Rdata1, Rdata2);
    end
    @(negedge clk);
    w = 1'b0;
    $display("[TB] test_write_r0 done");
  endtask

  task automatic test_write_all();
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      Raddr1 = 3'd0; Raddr2 = 3'(i); Wdata = 8'hFF; w = 1'b1;
      #1;
      // No bypass: before the edge the old value (0) is visible.
      tests_run++;
      if (Rdata2 !== 8'h00) begin
        tests_failed++;
        $display("FAIL pre_edge_r%0d: Rdata2=%h expected 00", i, Rdata2);
      end
      @(posedge clk); #1;
      tests_run++;
      if (Rdata2 !== 8'hFF || Rdata1 !== 8'h00) begin
        tests_failed++;
        $display("FAIL write_r%0d: Rdata1=%h Rdata2=%h expected 00 ff", i, Rdata1, Rdata2);
      end
    end
    tests_run++;
    if ($signed(Rdata2) != -1) begin
      tests_failed++;
      $display("FAIL signed_readback: Rdata2=%0d expected -1", $signed(Rdata2));
    end
    @(negedge clk);
    w = 1'b0;
    $display("[TB] test_write_all done");
  endtask

  task automatic test_readback();
    w = 1'b0;
    for (int i = 1; i < 8; i++) begin
      Raddr1 = 3'(i); Raddr2 = 3'(i);
      #1;
      tests_run++;
      if (Rdata1 !== 8'hFF || Rdata2 !== 8'hFF) begin
        tests_failed++;
        $display("FAIL readback_r%0d: Rdata1=%h Rdata2=%h expected ff ff", i, Rdata1, Rdata2);
      end
    end
    Raddr1 = 3'd0; Raddr2 = 3'd0;
    #1;
    tests_run++;
    if (Rdata1 !== 8'h00 || Rdata2 !== 8'h00) begin
      tests_failed++;
      $display("FAIL readback_r0: Rdata1=%h Rdata2=%h expected 00 00", Rdata1, Rdata2);
    end
    $display("[TB] test_readback done");
  endtask

  task automatic test_hold_overwrite();
    @(negedge clk);
    w = 1'b0; Wdata = 8'h5A; Raddr2 = 3'd3;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 1; i < 8; i++) begin
      Raddr1 = 3'(i);
      #1;
      tests_run++;
      if (Rdata1 !== 8'hFF) begin
        tests_failed++;
        $display("FAIL hold_r%0d: Rdata1=%h expected ff", i, Rdata1);
      end
    end
    @(negedge clk);
    w = 1'b1; Raddr2 = 3'd3; Wdata = 8'h5A;
    @(posedge clk); #1;
    tests_run++;
    if (Rdata2 !== 8'h5A) begin
      tests_failed++;
      $display("FAIL overwrite_r3: Rdata2=%h expected 5a", Rdata2);
    end
    @(negedge clk);
    w = 1'b0;
    Raddr1 = 3'd2; #1;
    tests_run++;
    if (Rdata1 !== 8'hFF) begin
      tests_failed++;
      $display("FAIL neighbour_r2: Rdata1=%h expected ff", Rdata1);
    end
    Raddr1 = 3'd4; #1;
    tests_run++;
    if (Rdata1 !== 8'hFF) begin
      tests_failed++;
      $display("FAIL neighbour_r4: Rdata1=%h expected ff", Rdata1);
    end
    Raddr1 = 3'd3; #1;
    tests_run++;
    if (Rdata1 !== Rdata2 || Rdata1 !== 8'h5A) begin
      tests_failed++;
      $display("FAIL same_addr_r3: Rdata1=%h Rdata2=%h expected 5a 5a", Rdata1, Rdata2);
    end
    $display("[TB] test_hold_overwrite done");
  endtask

  task automatic test_async_reset();
    // Pulse reset between edges with a write pending.
    @(negedge clk);
    w = 1'b1; Raddr2 = 3'd5; Raddr1 = 3'd6; Wdata = 8'h77;
    #2 n_reset = 1'b0;
    #1;
    tests_run++;
    if (Rdata1 !== 8'h00 || Rdata2 !== 8'h00) begin
      tests_failed++;
      $display("FAIL async_clear: Rdata1=%h Rdata2=%h expected 00 00", Rdata1, Rdata2);
    end
    #1 n_reset = 1'b1;
    // The first edge after release writes r5.
    @(posedge clk); #1;
    tests_run++;
    if (Rdata2 !== 8'h77 || Rdata1 !== 8'h00) begin
      tests_failed++;
      $display("FAIL write_after_release: Rdata1=%h Rdata2=%h expected 00 77", Rdata1, Rdata2);
    end
    @(negedge clk);
    w = 1'b0;
    for (int i = 1; i < 8; i++) begin
      if (i != 5) begin
        Raddr1 = 3'(i);
        #1;
        tests_run++;
        if (Rdata1 !== 8'h00) begin
          tests_failed++;
          $display("FAIL post_reset_r%0d: Rdata1=%h expected 00", i, Rdata1);
        end
      end
    end
    // Reset held across an edge overrides a write.
    @(negedge clk);
    w = 1'b1; Raddr2 = 3'd2; Wdata = 8'h11; n_reset = 1'b0;
    @(posedge clk); #1;
    tests_run++;
    if (Rdata2 !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_priority: Rdata2=%h expected 00", Rdata2);
    end
    @(negedge clk);
    w = 1'b0; n_reset = 1'b1;
    Raddr2 = 3'd5; #1;
    tests_run++;
    if (Rdata2 !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_clears_r5: Rdata2=%h expected 00", Rdata2);
    end
    $display("[TB] test_async_reset done");
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_write_r0();
    test_write_all();
    test_readback();
    test_hold_overwrite();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
